// File: rtl/sb_mem_target.sv
// Single-port word memory behind a simple request/grant bus with a fixed response latency.
// Every granted access gets exactly one response pulse; bad addresses report an error.
module sb_mem_target #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sb_addr_in,
  input  logic        sb_req_in,
  input  logic        sb_wr_in,
  input  logic [31:0] sb_wdata_in,
  output logic        sb_gnt_out,
  output logic [31:0] sb_read_data_out,
  output logic        sb_read_valid_out,
  output logic        sb_err_out
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 34 bits so a 2^30-word memory's byte span does not wrap to zero.
  localparam logic [33:0] SpanBytes = 34'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WaitLoad  = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]     offset;
  logic            addr_err;
  logic [IdxW-1:0] idx;

  assign offset   = sb_addr_in - BASE_ADDR;
  assign addr_err = (sb_addr_in[1:0] != 2'b00) || ({2'b00, offset} >= SpanBytes);
  assign idx      = offset[IdxW+1:2];

  assign sb_gnt_out = (state_q == StIdle) && sb_req_in && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sb_gnt_out) begin
          if (RD_LATENCY > 1) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read data is sampled at the grant edge so later writes cannot alter the response.
  always_ff @(posedge clk) begin
    if (sb_gnt_out) begin
      wr_q    <= sb_wr_in;
      err_q   <= addr_err;
      rdata_q <= (sb_wr_in || addr_err) ? 32'h0 : mem[idx];
    end
  end

  // Memory is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (sb_gnt_out && sb_wr_in && !addr_err) begin
      mem[idx] <= sb_wdata_in;
    end
  end

  assign sb_read_valid_out = (state_q == StResp) && !rst;
  assign sb_err_out        = sb_read_valid_out && err_q;
  assign sb_read_data_out  = (sb_read_valid_out && !wr_q && !err_q) ? rdata_q : 32'h0;

endmodule

// File: doc/sb_mem_target.md
SB_MEM_TARGET -- requirements
Module: sb_mem_target

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter RD_LATENCY, default 2, cycles from grant to response (legal range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sb_addr_in  input  32  byte address from the initiator.
REQ-007 SHALL have port sb_req_in  input  1  initiator request; held with addr/wr/wdata until granted.
REQ-008 SHALL have port sb_wr_in  input  1  1 = write, 0 = read.
REQ-009 SHALL have port sb_wdata_in  input  32  write data.
REQ-010 SHALL have port sb_gnt_out  output  1  request accepted this cycle.
REQ-011 SHALL have port sb_read_data_out  output  32  read data; valid only with sb_read_valid_out.
REQ-012 SHALL have port sb_read_valid_out  output  1  one-cycle response pulse for every granted read or write.
REQ-013 SHALL have port sb_err_out  output  1  error flag; meaningful only with sb_read_valid_out.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive sb_gnt_out = (state==IDLE) && sb_req_in && !rst, combinationally; never asserted in WAIT or RESP.
REQ-016 SHALL, on a grant edge, capture addr/wr/wdata and error status; next state WAIT if RD_LATENCY>1, else RESP.
REQ-017 SHALL count RD_LATENCY-1 cycles in WAIT, then enter RESP; with a grant in cycle N, sb_read_valid_out SHALL be high exactly in cycle N+RD_LATENCY.
REQ-018 SHALL assert sb_read_valid_out for exactly one cycle in RESP, then return to IDLE; earliest next grant is cycle N+RD_LATENCY+1.
REQ-019 SHALL flag error when addr[1:0]!=0 or (addr-BASE_ADDR) (unsigned, 32-bit wrap) >= DEPTH_WORDS*4.
REQ-020 SHALL commit a non-error write to mem[(addr-BASE_ADDR)>>2] at the grant edge.
REQ-021 SHALL, for a non-error read, output the word at that index as it was at the grant edge.
REQ-022 SHALL drive sb_read_data_out = 0 for writes, for error responses, and whenever sb_read_valid_out = 0.
REQ-023 SHALL drive sb_err_out = 1 only in the RESP cycle of an error transaction; errored writes SHALL NOT modify memory.
REQ-024 SHALL ignore sb_req_in, sb_wr_in, sb_addr_in and sb_wdata_in outside IDLE; capture occurs only at the grant edge.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, clear the latency counter, and drive sb_gnt_out, sb_read_valid_out, sb_err_out and sb_read_data_out to 0.
REQ-026 SHALL, on reset in WAIT or RESP, drop the pending response without a pulse; a write committed at an earlier grant edge SHALL remain.
REQ-027 Memory contents SHALL NOT be cleared by reset; reads of never-written words return undefined data.
REQ-028 SHALL accept a request in the first cycle with rst=0.

Verification
REQ-029 Parameters: defaults. Write 0x10/0xDEADBEEF granted in cycle 0 -> valid in cycle 2 with err=0, data=0. Read 0x10 -> valid 2 cycles after grant with data 0xDEADBEEF, err=0.
REQ-030 Read 0x1000 (=DEPTH_WORDS*4) -> valid with err=1, data=0. Write 0x12 -> err=1; a subsequent read of 0x10 still returns 0xDEADBEEF.
REQ-031 req held high continuously from cycle 0 -> gnt high in cycles 0, 3, 6; low in all other cycles; exactly one valid per grant.
REQ-032 rst pulsed in the cycle after a read grant -> no valid pulse. With rst=0 in the next cycle and req high, gnt is high in that same cycle.
REQ-033 RD_LATENCY=1 with BASE_ADDR=0x8000_0000 -> read 0x8000_0004 valid in cycle N+1 with err=0. Read 0x0000_0004 -> err=1.
